// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants: display modes, controller states,
// switch indices and the small decode helpers used by display_mode_ctrl.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [2:0] {
        MODE_BLACK    = 3'd0,
        MODE_GRADIENT = 3'd1,
        MODE_BLUE     = 3'd2,
        MODE_GREEN    = 3'd3,
        MODE_RED      = 3'd4,
        MODE_WHITE    = 3'd5
    } mode_t;

    typedef enum logic {MANUAL, DEMO} ctrl_state_t;

    // Colour switches sit in ascending priority so the highest set bit wins.
    localparam int NUM_SW      = 7;
    localparam int SW_GRADIENT = 0;
    localparam int SW_BLUE     = 1;
    localparam int SW_GREEN    = 2;
    localparam int SW_RED      = 3;
    localparam int SW_WHITE    = 4;
    localparam int SW_BOX      = 5;
    localparam int SW_DEMO     = 6;

    typedef struct packed {
        logic gradient;
        logic red;
        logic green;
        logic blue;
        logic white;
    } colour_t;

    function automatic mode_t manual_mode(input logic [4:0] sw);
        if (sw[SW_WHITE])         return MODE_WHITE;
        else if (sw[SW_RED])      return MODE_RED;
        else if (sw[SW_GREEN])    return MODE_GREEN;
        else if (sw[SW_BLUE])     return MODE_BLUE;
        else if (sw[SW_GRADIENT]) return MODE_GRADIENT;
        else                      return MODE_BLACK;
    endfunction

    function automatic mode_t demo_next(input mode_t m);
        case (m)
            MODE_GRADIENT: return MODE_RED;
            MODE_RED:      return MODE_GREEN;
            MODE_GREEN:    return MODE_BLUE;
            MODE_BLUE:     return MODE_WHITE;
            default:       return MODE_GRADIENT;
        endcase
    endfunction

    function automatic colour_t decode(input mode_t m);
        colour_t c;
        c          = '0;
        c.gradient = (m == MODE_GRADIENT);
        c.red      = (m == MODE_RED);
        c.green    = (m == MODE_GREEN);
        c.blue     = (m == MODE_BLUE);
        c.white    = (m == MODE_WHITE);
        return c;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a run-length debouncer: a new level is
// accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/display_mode_ctrl.sv
// Frame-synchronous MANUAL/DEMO mode controller; every mode and box change
// commits on the frame_tick edge so a frame is never split across modes.
module display_mode_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DEMO_FRAMES     = 120,
    parameter int V_ACTIVE        = vga_pkg::V_ACTIVE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sw_gradient,
    input  logic       sw_red,
    input  logic       sw_green,
    input  logic       sw_blue,
    input  logic       sw_white,
    input  logic       sw_box,
    input  logic       sw_demo,
    input  logic [9:0] xcounter,
    input  logic [9:0] ycounter,
    output logic       gradient,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       white,
    output logic       box_enable,
    output logic [2:0] mode,
    output logic       demo_active,
    output logic       frame_tick,
    output logic       mode_changed
);

    localparam int DCW = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;

    logic [NUM_SW-1:0] raw, db;
    assign raw = {sw_demo, sw_box, sw_white, sw_red, sw_green, sw_blue, sw_gradient};

    for (genvar i = 0; i < NUM_SW; i++) begin : g_db
        sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .stable (db[i])
        );
    end

    ctrl_state_t    state_q, state_d;
    mode_t          mode_q, mode_d, man_mode;
    logic           box_d, changed_d, tick_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    colour_t        col_q;

    assign man_mode = manual_mode(db[4:0]);
    assign tick_d   = (xcounter == 10'd0) && (ycounter == 10'(V_ACTIVE));

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        box_d   = box_enable;
        dcnt_d  = dcnt_q;
        if (frame_tick) begin
            case (state_q)
                MANUAL: begin
                    if (db[SW_DEMO]) begin
                        state_d = DEMO;
                        mode_d  = MODE_GRADIENT;
                        dcnt_d  = '0;
                        box_d   = 1'b1;
                    end else begin
                        mode_d = man_mode;
                        box_d  = db[SW_BOX];
                    end
                end
                default: begin
                    if (!db[SW_DEMO]) begin
                        state_d = MANUAL;
                        mode_d  = man_mode;
                        box_d   = db[SW_BOX];
                    end else begin
                        box_d = 1'b1;
                        if (dcnt_q == DCW'(DEMO_FRAMES - 1)) begin
                            mode_d = demo_next(mode_q);
                            dcnt_d = '0;
                        end else begin
                            dcnt_d = dcnt_q + DCW'(1);
                        end
                    end
                end
            endcase
        end
        changed_d = frame_tick && ((mode_d != mode_q) || (box_d != box_enable));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= MANUAL;
            mode_q       <= MODE_BLACK;
            box_enable   <= 1'b0;
            dcnt_q       <= '0;
            col_q        <= '0;
            frame_tick   <= 1'b0;
            mode_changed <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            box_enable   <= box_d;
            dcnt_q       <= dcnt_d;
            col_q        <= decode(mode_d);
            frame_tick   <= tick_d;
            mode_changed <= changed_d;
        end
    end

    assign mode        = mode_q;
    assign demo_active = (state_q == DEMO);
    assign gradient    = col_q.gradient;
    assign red         = col_q.red;
    assign green       = col_q.green;
    assign blue        = col_q.blue;
    assign white       = col_q.white;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// Directed bench for display_mode_ctrl on a shrunken 4x10 raster with the
// commit point at (0,8); expected modes are hand-derived per step.
module tb_display_mode_ctrl;

    localparam int VA = 8;
    localparam int HT = 4;
    localparam int VT = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sw_gradient, sw_red, sw_green, sw_blue, sw_white, sw_box, sw_demo;
    logic [9:0] x, y;
    logic       gradient, red, green, blue, white, box_enable, demo_active;
    logic       frame_tick, mode_changed;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;
    int ft_cnt = 0;
    int mc_cnt = 0;

    display_mode_ctrl #(.DEBOUNCE_CYCLES(4), .DEMO_FRAMES(2), .V_ACTIVE(VA)) dut (
        .clk(clk), .rst_n(rst_n),
        .sw_gradient(sw_gradient), .sw_red(sw_red), .sw_green(sw_green),
        .sw_blue(sw_blue), .sw_white(sw_white), .sw_box(sw_box), .sw_demo(sw_demo),
        .xcounter(x), .ycounter(y),
        .gradient(gradient), .red(red), .green(green), .blue(blue), .white(white),
        .box_enable(box_enable), .mode(mode), .demo_active(demo_active),
        .frame_tick(frame_tick), .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // one clock: sample post-edge outputs, then advance the raster
    task automatic cyc();
        @(posedge clk);
        #1;
        ft_cnt += int'(frame_tick);
        mc_cnt += int'(mode_changed);
        if (x == 10'(HT - 1)) begin
            x = '0;
            y = (y == 10'(VT - 1)) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
    endtask

    task automatic goto_tick();
        int n = 0;
        while (!(x == 10'd0 && y == 10'(VA)) && n < 200) begin
            cyc();
            n++;
        end
        chk("goto_tick", 32'(n < 200), 32'd1);
    endtask

    task automatic commit();
        goto_tick();
        cyc();
        chk("tick", 32'(frame_tick), 32'd1);
        cyc();
    endtask

    function automatic logic [4:0] col_of(input int m);
        case (m)
            1:       return 5'b00001;
            2:       return 5'b00010;
            3:       return 5'b00100;
            4:       return 5'b01000;
            5:       return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic check_out(input string tag, input int m, input bit box, input bit demo);
        chk({tag, "_mode"}, 32'(mode), 32'(m));
        chk({tag, "_col"}, 32'({white, red, green, blue, gradient}), 32'(col_of(m)));
        chk({tag, "_box"}, 32'(box_enable), 32'(box));
        chk({tag, "_demo"}, 32'(demo_active), 32'(demo));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int seq[5] = '{4, 3, 2, 5, 1};
        int prev;
        {sw_gradient, sw_red, sw_green, sw_blue, sw_white, sw_box, sw_demo} = '0;
        rst_n = 1'b0;
        x = '0;
        y = '0;

        // 1: reset values, idle frames
        repeat (3) cyc();
        check_out("rst", 0, 0, 0);
        chk("rst_ft", 32'(frame_tick), 32'd0);
        chk("rst_mc", 32'(mode_changed), 32'd0);
        rst_n = 1'b1;
        ft_cnt = 0;
        mc_cnt = 0;
        repeat (80) cyc();
        chk("t1_ticks", 32'(ft_cnt), 32'd2);
        chk("t1_mc", 32'(mc_cnt), 32'd0);
        commit();
        check_out("t1", 0, 0, 0);

        // 2: red commits exactly two cycles after the counters hit (0,VA)
        sw_red = 1'b1;
        goto_tick();
        chk("t2_pre", 32'(mode), 32'd0);
        mc_cnt = 0;
        cyc();
        chk("t2_ft", 32'(frame_tick), 32'd1);
        chk("t2_hold", 32'(mode), 32'd0);
        cyc();
        check_out("t2", 4, 0, 0);
        chk("t2_mc", 32'(mode_changed), 32'd1);
        cyc();
        chk("t2_ft_off", 32'(frame_tick), 32'd0);
        commit();
        chk("t2_mc_unchg", 32'(mode_changed), 32'd0);
        chk("t2_mc_once", 32'(mc_cnt), 32'd1);

        // 3: red released, 3-cycle blue glitch rejected, then white beats green
        sw_red = 1'b0;
        repeat (10) cyc();
        sw_blue = 1'b1;
        repeat (3) cyc();
        sw_blue = 1'b0;
        commit();
        check_out("t3_glitch", 0, 0, 0);
        chk("t3_mc", 32'(mode_changed), 32'd1);
        sw_white = 1'b1;
        sw_green = 1'b1;
        commit();
        check_out("t3_white", 5, 0, 0);

        // 4: demo cycles every 2 frames with box forced on
        sw_demo = 1'b1;
        sw_box  = 1'b0;
        commit();
        check_out("t4_enter", 1, 1, 1);
        chk("t4_enter_mc", 32'(mode_changed), 32'd1);
        prev = 1;
        foreach (seq[i]) begin
            commit();
            check_out("t4_hold", prev, 1, 1);
            chk("t4_hold_mc", 32'(mode_changed), 32'd0);
            commit();
            check_out("t4_step", seq[i], 1, 1);
            chk("t4_step_mc", 32'(mode_changed), 32'd1);
            prev = seq[i];
        end

        // 5: leaving demo commits the manual result on the same edge
        sw_white = 1'b0;
        sw_demo  = 1'b0;
        commit();
        check_out("t5", 3, 0, 0);

        // 6: async reset mid-frame while in demo showing red
        sw_demo = 1'b1;
        commit();
        check_out("t6_enter", 1, 1, 1);
        commit();
        commit();
        check_out("t6_red", 4, 1, 1);
        repeat (10) cyc();
        #2 rst_n = 1'b0;
        #1;
        check_out("t6_rst", 0, 0, 0);
        chk("t6_rst_mc", 32'(mode_changed), 32'd0);
        #3 rst_n = 1'b1;
        goto_tick();
        chk("t6_manual", 32'(demo_active), 32'd0);
        cyc();
        chk("t6_manual_ft", 32'(demo_active), 32'd0);
        cyc();
        check_out("t6_rearm", 1, 1, 1);
        chk("t6_rearm_mc", 32'(mode_changed), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
